dram_responder: RTL and testbench
=================================

Name: dram_responder

Overview:
- Memory-side responder for the processor's data-memory address path.
- Accepts a 16-bit address, optional write data and a read or write command from the processor control path, then services the request after a fixed programmable latency.
- Signals completion with a one-cycle done pulse; read data is held on the output afterwards.
- Sits between the memory address register / data path and the on-chip 8-bit pixel store used by the image downsampling flow.

Parameters:
- ADDR_WIDTH, 16, address width; memory depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 8, pixel/word width.
- READ_LATENCY, 2, cycles from request accept edge to read done edge; legal range 1..15.
- WRITE_LATENCY, 1, cycles from request accept edge to write done edge; legal range 1..15.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- addr_in  input  ADDR_WIDTH  request address, sampled on the accept edge.
- data_in  input  DATA_WIDTH  write data, sampled on the accept edge.
- read_req  input  1  read command, level-sampled while idle.
- write_req  input  1  write command, level-sampled while idle.
- data_out  output  DATA_WIDTH  read data; held until the next read completes.
- busy  output  1  high while a request is in flight.
- done  output  1  one-cycle pulse at request completion.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: busy=0, done=0, data_out=0, state=IDLE, latency counter=0. Memory array contents are not reset.
- States: IDLE, READ_WAIT, WRITE_WAIT.
- Request accept:
  - In IDLE, a rising edge with write_req=1 goes to WRITE_WAIT.
  - In IDLE, a rising edge with read_req=1 and write_req=0 goes to READ_WAIT.
  - Write has priority when both are high; the read is dropped, not queued.
- On accept:
  - addr_in and data_in are latched into internal registers; later input changes have no effect on the in-flight request.
  - busy=1 from the accept edge.
  - Counter loads the applicable latency minus 1.
- WAIT states: counter decrements each edge. At the edge where the counter reads 0, the request completes:
  - Read: data_out <= mem[latched addr].
  - Write: mem[latched addr] <= latched data; data_out unchanged.
  - done=1 for exactly one cycle, busy=0, state returns to IDLE.
- Latency: done is visible exactly READ_LATENCY / WRITE_LATENCY cycles after the accept edge. With latency 1, done is high in the cycle immediately after accept.
- Back-to-back: a request held high during the done cycle is accepted on the next edge, so the minimum issue interval is latency+1 cycles.
- Requests while busy are ignored and not queued. The requester must hold its request until it sees done.
- Read-after-write to the same address returns the newly written value.
- Address wrap: none needed. The full ADDR_WIDTH range is addressable and there are no out-of-range addresses.
- Reset mid-operation:
  - Aborts the in-flight request: no memory write occurs and no done pulse.
  - Outputs return to reset values.
  - Memory contents written before reset are retained.
- Read data is synchronous: there is no combinational path from addr_in to data_out.

Decomposition:
- Shared package (proc_mem_pkg):
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - State encoding constants: IDLE=2'b00, READ_WAIT=2'b01, WRITE_WAIT=2'b10.
  - Latency counter width constant (4).
- One sub-module, dram_array: single-port synchronous RAM with write enable, address, write data and registered read data, inferred as block RAM.
- dram_responder holds the FSM, latency counter, request latches and done/busy logic.

Test Plan:
1. Reset then idle: reset_n low 3 cycles, then high with no requests → busy=0, done=0, data_out=0x00 throughout.
2. Write then read, default latencies: write addr 0x1234, data 0xA5; wait for done; read 0x1234 → write done 1 cycle after accept; read done 2 cycles after accept with data_out=0xA5 on the same edge, held afterwards.
3. Simultaneous requests: read_req=write_req=1, addr 0x0010, data 0x3C → only the write executes (done after 1 cycle). A subsequent read of 0x0010 returns 0x3C.
4. Request while busy: during a READ_WAIT on 0x0000, pulse write_req to 0x0000 with 0x77 → write ignored. A later read of 0x0000 returns the prior value.
5. Reset mid-op: accept write 0x8000 ← 0x99, assert reset_n before done → no done pulse. A read of 0x8000 afterwards returns the old value; an earlier write to 0x0001 (0x42) still reads back 0x42.
6. Latency sweep: READ_LATENCY=1 and 5 → done exactly 1 and 5 cycles after accept. A request held through done is accepted on the next edge, giving a 2- and 6-cycle issue interval.

Source files
------------

// File: rtl/proc_mem_pkg.sv
// Shared definitions for the processor data-memory responder.
// Provides the default address/data widths, the FSM state encoding, the
// latency counter width and a helper that turns a latency into a counter
// preload value.
package proc_mem_pkg;

   localparam int ADDR_WIDTH_DEF = 16;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int CNT_WIDTH      = 4;

   localparam logic [1:0] IDLE       = 2'b00;
   localparam logic [1:0] READ_WAIT  = 2'b01;
   localparam logic [1:0] WRITE_WAIT = 2'b10;

   // Counter completes the request on the edge where it reads zero, so a
   // latency of N cycles preloads N-1.
   function automatic logic [CNT_WIDTH-1:0] lat_load(input int lat);
      return CNT_WIDTH'(lat - 1);
   endfunction

endpackage

// File: rtl/dram_array.sv
// Single-port synchronous RAM, read-first, with registered read data.
// Written in the plain form that maps onto block RAM; contents are not reset.
// Ports:
//   clock  rising-edge clock
//   we     write enable
//   addr   word address (read and write)
//   wdata  write data
//   rdata  registered read data, mem[addr] as sampled on the previous edge
module dram_array #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder for the data-memory address path. Accepts one read
// or write request while idle, completes it after a fixed latency, pulses
// done for one cycle and holds read data until the next read completes.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   addr_in         request address, latched on accept
//   data_in         write data, latched on accept
//   read_req        read command, sampled only while idle
//   write_req       write command, sampled only while idle (wins over read)
//   data_out        read data, updated on read completion
//   busy            high while a request is in flight
//   done            one-cycle completion pulse
module dram_responder
   import proc_mem_pkg::*;
#(
   parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  read_req,
   input  logic                  write_req,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  busy,
   output logic                  done
);

   logic [1:0]            state;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  ram_we;
   logic                  last;

   // While idle the RAM is addressed straight from addr_in so the accept edge
   // already starts the read; this is what lets a latency-1 read complete on
   // the very next edge. Once busy, the latched address keeps it stable.
   assign ram_addr = (state == IDLE) ? addr_in : addr_q;
   assign last     = (cnt == '0);
   assign ram_we   = (state == WRITE_WAIT) && last;

   dram_array #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_array (
      .clock(clock),
      .we   (ram_we),
      .addr (ram_addr),
      .wdata(data_q),
      .rdata(ram_rdata)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_out <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (write_req || read_req) begin
                  addr_q <= addr_in;
                  data_q <= data_in;
                  busy   <= 1'b1;
                  if (write_req) begin
                     state <= WRITE_WAIT;
                     cnt   <= lat_load(WRITE_LATENCY);
                  end else begin
                     state <= READ_WAIT;
                     cnt   <= lat_load(READ_LATENCY);
                  end
               end
            end
            READ_WAIT, WRITE_WAIT: begin
               if (last) begin
                  // RAM write fires off ram_we on this same edge.
                  if (state == READ_WAIT) data_out <= ram_rdata;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench: three responders with different latencies. The driver
// pushes one expectation per issued request; the monitor checks busy, done
// timing and data_out every falling edge against a reference memory model.
module tb_dram_responder;

   typedef struct {
      int          idx;
      bit          is_wr;
      logic [15:0] a;
      logic [7:0]  d;
      int          acc;
      int          dn;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  rr = '0;
   logic [2:0]  wr = '0;
   logic [15:0] addr_v [3];
   logic [7:0]  din_v  [3];
   logic [7:0]  dout_v [3];
   logic [2:0]  busy_v;
   logic [2:0]  done_v;

   int rlat [3] = '{2, 1, 5};
   int wlat [3] = '{1, 1, 3};

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   exp_t        q[$];
   logic [7:0]  mm [int];
   logic [7:0]  exp_dout [3] = '{8'h00, 8'h00, 8'h00};
   bit          mon_busy;
   exp_t        mon_e;
   int          mon_key;

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   dram_responder #(.READ_LATENCY(2), .WRITE_LATENCY(1)) dut0 (
      .clock(clock), .reset_n(reset_n), .addr_in(addr_v[0]), .data_in(din_v[0]),
      .read_req(rr[0]), .write_req(wr[0]), .data_out(dout_v[0]),
      .busy(busy_v[0]), .done(done_v[0]));

   dram_responder #(.READ_LATENCY(1), .WRITE_LATENCY(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .addr_in(addr_v[1]), .data_in(din_v[1]),
      .read_req(rr[1]), .write_req(wr[1]), .data_out(dout_v[1]),
      .busy(busy_v[1]), .done(done_v[1]));

   dram_responder #(.READ_LATENCY(5), .WRITE_LATENCY(3)) dut2 (
      .clock(clock), .reset_n(reset_n), .addr_in(addr_v[2]), .data_in(din_v[2]),
      .read_req(rr[2]), .write_req(wr[2]), .data_out(dout_v[2]),
      .busy(busy_v[2]), .done(done_v[2]));

   // Monitor: cycle index cyc == k at the falling edge after rising edge k.
   // A request accepted at edge acc is busy for cyc in [acc, acc+lat) and
   // shows done at cyc == acc+lat.
   always @(negedge clock) begin
      if (!reset_n) begin
         q.delete();
         for (int i = 0; i < 3; i++) begin
            exp_dout[i] = 8'h00;
            vectors++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || dout_v[i] !== 8'h00) begin
               miscompares++;
               $display("FAIL reset[%0d] cyc %0d: busy %b done %b dout %h, want 0 0 00",
                        i, cyc, busy_v[i], done_v[i], dout_v[i]);
            end
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            mon_busy = 1'b0;
            foreach (q[k])
               if (q[k].idx == i && cyc >= q[k].acc && cyc < q[k].dn) mon_busy = 1'b1;
            vectors++;
            if (busy_v[i] !== mon_busy) begin
               miscompares++;
               $display("FAIL busy[%0d] cyc %0d: got %b want %b", i, cyc, busy_v[i], mon_busy);
            end
            if (done_v[i] === 1'b1) begin
               vectors++;
               if (q.size() == 0 || q[0].idx != i || q[0].dn != cyc) begin
                  miscompares++;
                  $display("FAIL done[%0d] cyc %0d: unexpected pulse, want at cyc %0d",
                           i, cyc, (q.size() != 0 && q[0].idx == i) ? q[0].dn : -1);
               end else begin
                  mon_e = q.pop_front();
                  mon_key = i * 65536 + int'(mon_e.a);
                  if (mon_e.is_wr) mm[mon_key] = mon_e.d;
                  else if (mm.exists(mon_key)) exp_dout[i] = mm[mon_key];
               end
            end else if (done_v[i] !== 1'b0) begin
               vectors++;
               miscompares++;
               $display("FAIL done[%0d] cyc %0d: got %b want 0/1", i, cyc, done_v[i]);
            end else if (q.size() != 0 && q[0].idx == i && q[0].dn <= cyc) begin
               vectors++;
               miscompares++;
               $display("FAIL done[%0d] cyc %0d: got 0 want pulse at cyc %0d", i, cyc, q[0].dn);
               void'(q.pop_front());
            end
            vectors++;
            if (dout_v[i] !== exp_dout[i]) begin
               miscompares++;
               $display("FAIL data_out[%0d] cyc %0d: got %h want %h", i, cyc, dout_v[i], exp_dout[i]);
            end
         end
      end
   end

   // Drive a request at the current falling edge; the next rising edge accepts it.
   task automatic issue(input int i, input bit w, input bit r,
                        input logic [15:0] a, input logic [7:0] d);
      exp_t e;
      wr[i] = w;
      rr[i] = r;
      addr_v[i] = a;
      din_v[i] = d;
      if (w || r) begin
         e.idx = i;
         e.is_wr = w;
         e.a = a;
         e.d = d;
         e.acc = cyc + 1;
         e.dn = e.acc + (w ? wlat[i] : rlat[i]);
         q.push_back(e);
      end
   endtask

   // Wait (bounded) for done; optionally scramble inputs while in flight to
   // show the latched request is unaffected. Returns on the done falling edge
   // with requests still asserted.
   task automatic wait_done(input int i, input bit scr);
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (done_v[i] === 1'b1) return;
         if (scr) begin
            addr_v[i] = 16'($urandom);
            din_v[i] = 8'($urandom);
         end
      end
      vectors++;
      miscompares++;
      $display("FAIL timeout[%0d] cyc %0d: got no done want done within 40 cycles", i, cyc);
      rr[i] = 1'b0;
      wr[i] = 1'b0;
      q.delete();
   endtask

   task automatic xact(input int i, input bit w, input bit r,
                       input logic [15:0] a, input logic [7:0] d);
      issue(i, w, r, a, d);
      wait_done(i, 1'b1);
      rr[i] = 1'b0;
      wr[i] = 1'b0;
   endtask

   logic [15:0] pool [8] = '{16'h0000, 16'hFFFF, 16'h1234, 16'h8000,
                             16'h0001, 16'h00FF, 16'hABCD, 16'h7FFF};
   bit wrote [3][8];

   initial begin
      for (int i = 0; i < 3; i++) begin
         addr_v[i] = '0;
         din_v[i] = '0;
         for (int k = 0; k < 8; k++) wrote[i][k] = 1'b0;
      end

      // Reset then idle
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      // Write then read with default latencies; idle cycles check the hold
      xact(0, 1, 0, 16'h1234, 8'hA5);
      xact(0, 0, 1, 16'h1234, 8'h00);
      repeat (3) @(negedge clock);

      // Both requests high: only the write runs
      xact(0, 1, 1, 16'h0010, 8'h3C);
      xact(0, 0, 1, 16'h0010, 8'h00);

      // Write pulsed while a read is in flight is ignored
      xact(0, 1, 0, 16'h0000, 8'h5A);
      issue(0, 0, 1, 16'h0000, 8'h00);
      @(negedge clock);
      rr[0] = 1'b0;
      wr[0] = 1'b1;
      addr_v[0] = 16'h0000;
      din_v[0] = 8'h77;
      @(negedge clock);
      wr[0] = 1'b0;
      wait_done(0, 1'b0);
      xact(0, 0, 1, 16'h0000, 8'h00);

      // Reset in the middle of a write aborts it; earlier writes survive
      xact(0, 1, 0, 16'h0001, 8'h42);
      xact(0, 1, 0, 16'h8000, 8'h11);
      issue(0, 1, 0, 16'h8000, 8'h99);
      @(negedge clock);
      #1 reset_n = 1'b0;
      rr = '0;
      wr = '0;
      repeat (2) @(negedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      xact(0, 0, 1, 16'h8000, 8'h00);
      xact(0, 0, 1, 16'h0001, 8'h00);

      // Latency sweep with requests held through done (back-to-back)
      xact(1, 1, 0, 16'h4444, 8'h5E);
      issue(1, 0, 1, 16'h4444, 8'h00);
      wait_done(1, 1'b0);
      issue(1, 0, 1, 16'h4444, 8'h00);
      wait_done(1, 1'b0);
      rr[1] = 1'b0;
      xact(2, 1, 0, 16'h2222, 8'hC3);
      issue(2, 0, 1, 16'h2222, 8'h00);
      wait_done(2, 1'b0);
      issue(2, 0, 1, 16'h2222, 8'h00);
      wait_done(2, 1'b0);
      rr[2] = 1'b0;

      // Randomized traffic on every instance
      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < 40; n++) begin
            int k;
            int op;
            logic [7:0] d;
            k = $urandom_range(0, 7);
            op = $urandom_range(0, 3);
            d = 8'($urandom);
            if (op >= 2 && wrote[i][k]) begin
               issue(i, 1'b0, 1'b1, pool[k], d);
            end else begin
               issue(i, 1'b1, op == 0, pool[k], d);
               wrote[i][k] = 1'b1;
            end
            wait_done(i, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
               rr[i] = 1'b0;
               wr[i] = 1'b0;
               repeat ($urandom_range(0, 2)) @(negedge clock);
            end
         end
         rr[i] = 1'b0;
         wr[i] = 1'b0;
         @(negedge clock);
      end

      repeat (4) @(negedge clock);
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d outstanding want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
